alu_seq_unit: RTL

Parametrised, multi-cycle successor to the combinational ALU control decode. Decodes `ALUop`/`func` and also executes the operation on `WIDTH`-bit operands, returning a registered result.
- Single-cycle ops: and, or, add, sub, xor, nor, nand, slt.
- Iterative ops: logical shifts, arithmetic shift and a shift-add multiply, all behind a start/busy/done handshake.
- Sits between the register-file read stage and writeback; the processor control FSM stalls on `busy`.

---
 rtl/alu_seq_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: decodes ALUop/func, runs single-cycle ops directly and
// shifts/multiply one bit per cycle behind a start/busy/done handshake.
module alu_seq_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       ALUop,
   input  logic [3:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             illegal
);

   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic {IDLE, EXEC} state_e;

   // Ordering of the first twelve entries matches the func encoding.
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_NAND, OP_XOR, OP_SLT,
      OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
   } op_e;

   state_e           state, state_d;
   op_e              op_q, op_d, dec_op, s_op;
   logic [WIDTH-1:0] acc, acc_d, mc, mc_d, mp, mp_d;
   logic [WIDTH-1:0] s_acc, s_mc, s_mp, step_acc, step_mc, step_mp;
   logic [WIDTH-1:0] alu_res, result_d;
   logic [SHW-1:0]   cnt, cnt_d, n;
   logic             zero_d, busy_d, done_d, illegal_d, is_shift;

   assign n = b[SHW-1:0];

   // Operation decode and single-cycle datapath
   always_comb begin
      dec_op  = OP_ILL;
      alu_res = '0;
      case (ALUop)
         2'd0: dec_op = OP_ADD;
         2'd1: dec_op = OP_SUB;
         2'd3: dec_op = OP_OR;
         default: dec_op = (func >= 4'd12) ? OP_ILL : op_e'(func);
      endcase
      is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
      case (dec_op)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_NOR:  alu_res = ~(a | b);
         OP_NAND: alu_res = ~(a & b);
         OP_XOR:  alu_res = a ^ b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: alu_res = '0;
      endcase
   end

   // One iteration of shift or shift-add multiply; fed from the inputs in
   // the accept cycle and from the working registers while executing.
   always_comb begin
      if (state == IDLE) begin
         s_op  = dec_op;
         s_acc = (dec_op == OP_MUL) ? '0 : a;
         s_mc  = a;
         s_mp  = b;
      end else begin
         s_op  = op_q;
         s_acc = acc;
         s_mc  = mc;
         s_mp  = mp;
      end
      step_acc = s_acc;
      step_mc  = s_mc;
      step_mp  = s_mp;
      case (s_op)
         OP_SLL: step_acc = s_acc << 1;
         OP_SRL: step_acc = s_acc >> 1;
         OP_SRA: step_acc = {s_acc[WIDTH-1], s_acc[WIDTH-1:1]};
         OP_MUL: begin
            step_acc = s_acc + (s_mp[0] ? s_mc : '0);
            step_mc  = s_mc << 1;
            step_mp  = s_mp >> 1;
         end
         default: ;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state;
      op_d      = op_q;
      acc_d     = acc;
      mc_d      = mc;
      mp_d      = mp;
      cnt_d     = cnt;
      result_d  = result;
      illegal_d = illegal;
      busy_d    = busy;
      done_d    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (dec_op == OP_MUL || (is_shift && n > SHW'(1))) begin
                  state_d = EXEC;
                  busy_d  = 1'b1;
                  op_d    = dec_op;
                  acc_d   = step_acc;
                  mc_d    = step_mc;
                  mp_d    = step_mp;
                  cnt_d   = (dec_op == OP_MUL) ? SHW'(WIDTH - 1) : n - SHW'(1);
               end else begin
                  done_d    = 1'b1;
                  illegal_d = (dec_op == OP_ILL);
                  if (is_shift) result_d = (n == '0) ? a : step_acc;
                  else          result_d = alu_res;
               end
            end
         end
         EXEC: begin
            acc_d = step_acc;
            mc_d  = step_mc;
            mp_d  = step_mp;
            cnt_d = cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
               state_d   = IDLE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               result_d  = step_acc;
               illegal_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= OP_ADD;
         acc     <= '0;
         mc      <= '0;
         mp      <= '0;
         cnt     <= '0;
         result  <= '0;
         zero    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_d;
         op_q    <= op_d;
         acc     <= acc_d;
         mc      <= mc_d;
         mp      <= mp_d;
         cnt     <= cnt_d;
         result  <= result_d;
         zero    <= zero_d;
         busy    <= busy_d;
         done    <= done_d;
         illegal <= illegal_d;
      end
   end

endmodule
